// File: rtl/ttt_board_engine.sv
// rtl/ttt_board_engine.sv - N x N tic-tac-toe game-state engine
// Owns the board, cursor and turn order; after each mark, one candidate line is scanned per cycle.
module ttt_board_engine #(
  parameter int N = 3,
  localparam int CW = $clog2(N),
  localparam int LW = $clog2(2*N+2),
  localparam int MW = $clog2(N*N+1)
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              mv_up,
  input  logic              mv_down,
  input  logic              mv_left,
  input  logic              mv_right,
  input  logic              place,
  input  logic              new_game,
  output logic [2*N*N-1:0]  board,
  output logic [CW-1:0]     sel_row,
  output logic [CW-1:0]     sel_col,
  output logic [1:0]        turn,
  output logic              busy,
  output logic              illegal,
  output logic              game_over,
  output logic [1:0]        winner,
  output logic [LW-1:0]     win_line,
  output logic [MW-1:0]     move_cnt
);

  typedef enum logic [1:0] {PLAY, CHECK, WIN, DRAW} state_t;

  state_t          state;
  logic [1:0]      start_player;
  logic [LW-1:0]   line;
  logic            line_full;
  logic [1:0]      cur_cell;
  int              cur_idx;

  always_comb begin
    cur_idx  = int'(sel_row) * N + int'(sel_col);
    cur_cell = board[2*cur_idx +: 2];
  end

  // Map line index to its N cells: rows, then columns, then the two diagonals.
  always_comb begin
    int r;
    int c;
    r = 0;
    c = 0;
    line_full = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (int'(line) < N) begin
        r = int'(line);
        c = i;
      end else if (int'(line) < 2*N) begin
        r = i;
        c = int'(line) - N;
      end else if (int'(line) == 2*N) begin
        r = i;
        c = i;
      end else begin
        r = i;
        c = N - 1 - i;
      end
      if (board[2*(r*N+c) +: 2] != turn) line_full = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= PLAY;
      start_player <= 2'b01;
      turn         <= 2'b01;
      board        <= '0;
      sel_row      <= '0;
      sel_col      <= '0;
      busy         <= 1'b0;
      illegal      <= 1'b0;
      game_over    <= 1'b0;
      winner       <= 2'b00;
      win_line     <= '0;
      move_cnt     <= '0;
      line         <= '0;
    end else begin
      illegal <= 1'b0;
      if (new_game) begin
        start_player <= ~start_player;
        turn         <= ~start_player;
        board        <= '0;
        sel_row      <= '0;
        sel_col      <= '0;
        move_cnt     <= '0;
        winner       <= 2'b00;
        win_line     <= '0;
        line         <= '0;
        busy         <= 1'b0;
        game_over    <= 1'b0;
        state        <= PLAY;
      end else begin
        case (state)
          PLAY: begin
            if (place) begin
              if (cur_cell == 2'b00) begin
                board[2*cur_idx +: 2] <= turn;
                move_cnt <= move_cnt + 1'b1;
                line     <= '0;
                busy     <= 1'b1;
                state    <= CHECK;
              end else begin
                illegal <= 1'b1;
              end
            end else if (mv_up) begin
              sel_row <= (sel_row == '0) ? CW'(N-1) : sel_row - 1'b1;
            end else if (mv_down) begin
              sel_row <= (sel_row == CW'(N-1)) ? '0 : sel_row + 1'b1;
            end else if (mv_left) begin
              sel_col <= (sel_col == '0) ? CW'(N-1) : sel_col - 1'b1;
            end else if (mv_right) begin
              sel_col <= (sel_col == CW'(N-1)) ? '0 : sel_col + 1'b1;
            end
          end
          CHECK: begin
            // The win test is checked before draw so a winning final mark is reported as WIN.
            if (line_full) begin
              winner    <= turn;
              win_line  <= line;
              busy      <= 1'b0;
              game_over <= 1'b1;
              state     <= WIN;
            end else if (line == LW'(2*N+1)) begin
              busy <= 1'b0;
              if (move_cnt == MW'(N*N)) begin
                game_over <= 1'b1;
                state     <= DRAW;
              end else begin
                turn  <= ~turn;
                state <= PLAY;
              end
            end else begin
              line <= line + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/ttt_board_engine.md
Name: ttt_board_engine

Overview:
- Sequential game-state engine for an N×N tic-tac-toe board.
- Owns the cell array, the cursor, turn alternation, move legality and win/draw detection.
- Its outputs drive the video controller's per-cell sprite selectors and selected-cell input, replacing the hard-wired cell assignments at the top level.
- Win detection is a multi-cycle line scan, so the cost stays bounded as N grows.

Parameters:
- N, 3, board dimension (legal 3..8); board has N*N cells; a win is N in a row.
- CW, $clog2(N), width of row and column indices (derived, not overridden).

Ports:
- CLOCK_50  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- mv_up, mv_down, mv_left, mv_right  input  1 each  cursor move requests; debounced single-cycle pulses.
- place  input  1  place the current player's mark at the cursor; single-cycle pulse.
- new_game  input  1  clear the board and start a new game; single-cycle pulse.
- board  output  2*N*N  cell codes; cell (r,c) at bits [2*(r*N+c)+1 : 2*(r*N+c)]; 00 = empty, 01 = player 1, 10 = player 2; 11 is never written.
- sel_row, sel_col  output  CW each  cursor position.
- turn  output  2  code of the player to move (01 or 10).
- busy  output  1  high while in CHECK.
- illegal  output  1  one-cycle pulse when place targets an occupied cell.
- game_over  output  1  high in WIN or DRAW.
- winner  output  2  winning player's code in WIN, else 00.
- win_line  output  $clog2(2N+2)  winning line index, valid in WIN.
- move_cnt  output  $clog2(N*N+1)  marks placed this game.

Behaviour:
- Reset values:
  - board all 00; sel_row = sel_col = 0; turn = 01.
  - Internal start_player = 01.
  - busy = 0, illegal = 0, game_over = 0, winner = 00, win_line = 0, move_cnt = 0.
  - State = PLAY.
- Reset has priority over every input.
- States: PLAY, CHECK, WIN, DRAW.
- new_game, in any state (including mid-CHECK), takes effect on the next cycle:
  - start_player toggles, and turn = the new start_player.
  - board cleared, cursor set to (0,0), move_cnt = 0, winner = 00, win_line = 0.
  - State = PLAY.
  - new_game beats place and all moves in the same cycle.
- PLAY, cursor moves:
  - Priority up > down > left > right; at most one move is applied per cycle.
  - The cursor updates on the next cycle.
  - Moves wrap within the row or column: up from row 0 goes to row N-1; right from col N-1 goes to col 0.
- PLAY, place:
  - place beats moves in the same cycle; the cursor does not change.
  - If the cell is empty: the cell is written with turn and move_cnt increments, both on the next cycle. The engine then enters CHECK with line counter l = 0.
  - If the cell is occupied: illegal pulses for exactly one cycle, and nothing else changes.
- CHECK: one line is evaluated per cycle.
  - l = 0..N-1 are rows; l = N..2N-1 are columns l-N.
  - l = 2N is the main diagonal (r = c); l = 2N+1 is the anti-diagonal (c = N-1-r).
  - If all N cells of line l equal turn: go to WIN, with winner = turn and win_line = l.
  - Else if l = 2N+1 and move_cnt = N*N: go to DRAW.
  - Else if l = 2N+1: toggle turn and go to PLAY.
  - Otherwise l increments.
  - All moves and place inputs are ignored during CHECK; illegal stays 0.
- Timing: place accepted at edge t gives board and move_cnt updated at t+1 and busy = 1 from t+1.
  - Win on line l: state is WIN at t+2+l.
  - No win: state is PLAY or DRAW at t+2N+3.
- WIN and DRAW are terminal: game_over = 1, and all inputs except reset and new_game are ignored.
- A win on the final cell is reported as WIN, not DRAW.
- The checked line always belongs to the mover's code, so a stale opposing line can never be reported.

Test Plan:
- Reset, N=3:
  - Assert reset for 2 cycles → board = 18'h0, cursor (0,0), turn = 01, busy = 0, game_over = 0, move_cnt = 0.
- Cursor wrap and priority, N=3:
  - mv_left at (0,0) → cursor (0,2); mv_up → (2,2).
  - mv_up and mv_right in the same cycle → only up is applied: (1,2).
- Illegal move:
  - place at (1,1) → cell 4 = 01, busy for 8 cycles, then turn = 10.
  - place again at (1,1) → illegal high for exactly 1 cycle; board unchanged; move_cnt = 1.
- Row win, N=3:
  - P1 places at (0,0), (0,1), (0,2), with P2 at (1,0), (1,1).
  - After the fifth place at edge t → WIN at t+2, winner = 01, win_line = 0, game_over = 1.
  - Further places are ignored.
- Draw, N=3:
  - Fill the board with sequence 0,1,2,4,3,5,7,6,8 (no line) → after the final place at edge t: DRAW at t+9, winner = 00, move_cnt = 9.
- new_game mid-CHECK and N=4 anti-diagonal:
  - new_game while busy → next cycle board cleared, PLAY, turn = 10 (start toggled).
  - With N=4, player 10 completing (0,3), (1,2), (2,1), (3,0) → WIN, win_line = 9.
